mmu_port_arbiter: RTL and testbench

- Round-robin arbiter sharing the single MMU memory port (mem_*) between NREQ requesters: forward-pass engine, back_prop weight/bias updater, host loader.
- Latches the winner's command and holds it stable on the memory side until mem_ack_i, then returns read data and a one-cycle ack.
- A lock lets back_prop perform its read-then-write of a weight/bias without interleaving from other requesters.

---
 rtl/mmu_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mmu_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_port_arbiter.sv
// Round-robin arbiter sharing one MMU memory port among NREQ requesters, with an owner lock for RMW.
// Optional BUSY watchdog enabled by defining MMU_ARB_TIMEOUT_EN.
module mmu_port_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ*AW-1:0] adr_i,
    input  logic [NREQ*DW-1:0] dat_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    ack_o,
    output logic [DW-1:0]      dat_o,
    output logic               err_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [AW-1:0]      mem_adr_o,
    output logic [DW-1:0]      mem_dat_o,
    input  logic [DW-1:0]      mem_dat_i,
    input  logic               mem_ack_i
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, own_q, own_d;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic            err_q, err_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_adr_q, mem_adr_d;
    logic [DW-1:0]   mem_dat_q, mem_dat_d;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [IW-1:0]   win;
    logic            issue;
    logic [IW-1:0]   issue_idx;
    logic            timeout_hit;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

`ifdef MMU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero in the first BUSY cycle and counts BUSY cycles elapsed.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY) cnt_d = cnt_q + 1'b1;
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A requester in its ack cycle is masked so it cannot be re-granted immediately.
    always_comb begin
        int            c;
        logic [IW-1:0] cidx;
        elig  = req_i & ~ack_q;
        found = 1'b0;
        win   = '0;
        c     = 0;
        cidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr_q) + i;
            if (c >= NREQ) c = c - NREQ;
            cidx = IW'(c);
            if (!found && elig[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        own_d     = own_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        dat_d     = dat_q;
        err_d     = 1'b0;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        mem_adr_d = mem_adr_q;
        mem_dat_d = mem_dat_q;
        issue     = 1'b0;
        issue_idx = own_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    issue     = 1'b1;
                    issue_idx = win;
                    ptr_d     = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    ack_d     = onehot(own_q);
                    dat_d     = mem_we_q ? '0 : mem_dat_i;
                    if (lock_i[own_q]) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (timeout_hit) begin
                    // Watchdog abort always releases the lock.
                    mem_req_d = 1'b0;
                    ack_d     = onehot(own_q);
                    err_d     = 1'b1;
                    dat_d     = '0;
                    state_d   = IDLE;
                    gnt_d     = '0;
                end
            end
            HOLD: begin
                if (elig[own_q]) begin
                    issue = 1'b1;
                end else if (!lock_i[own_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            state_d   = BUSY;
            own_d     = issue_idx;
            gnt_d     = onehot(issue_idx);
            mem_req_d = 1'b1;
            mem_we_d  = we_i[issue_idx];
            mem_adr_d = adr_i[int'(issue_idx)*AW +: AW];
            mem_dat_d = dat_i[int'(issue_idx)*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            dat_q     <= '0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_dat_q <= mem_dat_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign err_o     = err_q;
    assign mem_req_o = mem_req_q;
    assign mem_we_o  = mem_we_q;
    assign mem_adr_o = mem_adr_q;
    assign mem_dat_o = mem_dat_q;
endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Bench for mmu_port_arbiter: grant table, directed multi-cycle sequences and a randomized run
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mmu_port_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 8;
`ifdef MMU_ARB_TIMEOUT_EN
    localparam bit TO_EN     = 1'b1;
    localparam int BP_CYCLES = TO - 2;
`else
    localparam bit TO_EN     = 1'b0;
    localparam int BP_CYCLES = 20;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_i, we_i, lock_i;
    logic [NREQ*AW-1:0] adr_i;
    logic [NREQ*DW-1:0] dat_i;
    logic [NREQ-1:0]    gnt_o, ack_o;
    logic [DW-1:0]      dat_o;
    logic               err_o, mem_req_o, mem_we_o;
    logic [AW-1:0]      mem_adr_o;
    logic [DW-1:0]      mem_dat_o, mem_dat_i;
    logic               mem_ack_i;

    mmu_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .adr_i(adr_i), .dat_i(dat_i), .gnt_o(gnt_o), .ack_o(ack_o), .dat_o(dat_o),
        .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dut_vec();
        return {gnt_o, ack_o, dat_o, err_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o};
    endfunction

    // Reference model: tracks who owns the port and what was latched, phrase by phrase.
    int              m_phase;   // 0 free, 1 access outstanding, 2 owner holds lock
    logic [1:0]      m_ptr, m_own;
    int              m_wait;
    logic [NREQ-1:0] m_gnt, m_ack;
    logic [DW-1:0]   m_dat, m_wdat;
    logic            m_err, m_req, m_we;
    logic [AW-1:0]   m_adr;

    function automatic logic [127:0] model_vec();
        return {m_gnt, m_ack, m_dat, m_err, m_req, m_we, m_adr, m_wdat};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_own = 0; m_wait = 0;
        m_gnt = 0; m_ack = 0; m_dat = 0; m_wdat = 0; m_err = 0; m_req = 0; m_we = 0; m_adr = 0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] cand;
        logic [1:0]      c;
        bit              take;
        cand  = req_i & ~m_ack;
        m_ack = '0;
        m_err = 1'b0;
        take  = 1'b0;
        if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                c = 2'((int'(m_ptr) + k) % NREQ);
                if (!take && cand[c]) begin
                    take  = 1'b1;
                    m_own = c;
                    m_ptr = 2'((int'(c) + 1) % NREQ);
                end
            end
        end else if (m_phase == 1) begin
            m_wait++;
            if (mem_ack_i) begin
                m_req        = 1'b0;
                m_ack[m_own] = 1'b1;
                m_dat        = m_we ? '0 : mem_dat_i;
                if (lock_i[m_own]) m_phase = 2;
                else begin m_phase = 0; m_gnt = '0; end
            end else if (TO_EN && m_wait == TO) begin
                m_req        = 1'b0;
                m_ack[m_own] = 1'b1;
                m_err        = 1'b1;
                m_dat        = '0;
                m_phase      = 0;
                m_gnt        = '0;
            end
        end else begin
            if (cand[m_own]) take = 1'b1;
            else if (!lock_i[m_own]) begin m_phase = 0; m_gnt = '0; end
        end
        if (take) begin
            m_phase = 1;
            m_wait  = 0;
            m_gnt   = '0;
            m_gnt[m_own] = 1'b1;
            m_req   = 1'b1;
            m_we    = we_i[m_own];
            m_adr   = adr_i[int'(m_own)*AW +: AW];
            m_wdat  = dat_i[int'(m_own)*DW +: DW];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = '0; we_i = '0; lock_i = '0; adr_i = '0; dat_i = '0;
        mem_ack_i = 1'b0; mem_dat_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!mem_req_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(mem_req_o), 128'(1));
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  gnt;
        logic [31:0] adr;
        logic        mreq;
    } vec_t;

    vec_t            tbl[8];
    logic [2:0]      exp_g;

    initial begin
        tbl[0] = '{3'b001, 3'b001, 32'h1000, 1'b1};
        tbl[1] = '{3'b010, 3'b010, 32'h1010, 1'b1};
        tbl[2] = '{3'b100, 3'b100, 32'h1020, 1'b1};
        tbl[3] = '{3'b011, 3'b001, 32'h1000, 1'b1};
        tbl[4] = '{3'b110, 3'b010, 32'h1010, 1'b1};
        tbl[5] = '{3'b101, 3'b001, 32'h1000, 1'b1};
        tbl[6] = '{3'b111, 3'b001, 32'h1000, 1'b1};
        tbl[7] = '{3'b000, 3'b000, 32'h0000, 1'b0};

        rst = 1'b1;
        req_i = '0; we_i = '0; lock_i = '0; adr_i = '0; dat_i = '0;
        mem_ack_i = 1'b0; mem_dat_i = '0;
        #1;
        check("reset_outputs", dut_vec(), 128'(0));

        // First grant from pointer 0 for each request pattern
        for (int i = 0; i < 8; i++) begin
            do_reset();
            adr_i = {32'h1020, 32'h1010, 32'h1000};
            req_i = tbl[i].req;
            @(negedge clk);
            check("table_grant", {gnt_o, mem_req_o, mem_adr_o}, {tbl[i].gnt, tbl[i].mreq, tbl[i].adr});
        end

        // Single read with ack three cycles after the request
        do_reset();
        req_i = 3'b001;
        adr_i = {32'h0, 32'h0, 32'h100};
        @(negedge clk);
        check("single_issue", {gnt_o, mem_req_o, mem_we_o, mem_adr_o}, {3'b001, 1'b1, 1'b0, 32'h100});
        @(negedge clk);
        @(negedge clk);
        mem_ack_i = 1'b1;
        mem_dat_i = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("single_ack", {ack_o, dat_o, err_o, mem_req_o, gnt_o}, {3'b001, 32'hDEADBEEF, 1'b0, 1'b0, 3'b000});
        @(negedge clk);
        check("single_no_reissue", {ack_o, mem_req_o, gnt_o}, {3'b000, 1'b0, 3'b000});
        req_i = '0;

        // Round-robin with all three requesting
        do_reset();
        req_i = 3'b111;
        for (int i = 0; i < 6; i++) begin
            exp_g = 3'(1 << (i % 3));
            wait_req("rr_wait");
            check("rr_grant", 128'(gnt_o), 128'(exp_g));
            mem_ack_i = 1'b1;
            @(negedge clk);
            mem_ack_i = 1'b0;
            check("rr_ack", 128'(ack_o), 128'(exp_g));
        end
        req_i = '0;

        // Locked read-modify-write by requester 1 while requester 0 waits
        do_reset();
        req_i  = 3'b010;
        lock_i = 3'b010;
        adr_i  = {32'h0, 32'h200, 32'h300};
        @(negedge clk);
        req_i = 3'b011;
        check("lock_rd_issue", {gnt_o, mem_req_o, mem_we_o, mem_adr_o}, {3'b010, 1'b1, 1'b0, 32'h200});
        mem_ack_i = 1'b1;
        mem_dat_i = 32'h77;
        @(negedge clk);
        mem_ack_i = 1'b0;
        we_i  = 3'b010;
        dat_i = {32'h0, 32'h5, 32'h0};
        check("lock_rd_ack", {ack_o, dat_o, gnt_o}, {3'b010, 32'h77, 3'b010});
        @(negedge clk);
        check("lock_hold", {gnt_o, mem_req_o}, {3'b010, 1'b0});
        @(negedge clk);
        check("lock_wr_issue", {gnt_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o},
              {3'b010, 1'b1, 1'b1, 32'h200, 32'h5});
        mem_ack_i = 1'b1;
        lock_i    = 3'b000;
        req_i     = 3'b001;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("lock_wr_ack", {ack_o, dat_o, gnt_o}, {3'b010, 32'h0, 3'b000});
        @(negedge clk);
        check("lock_release_gnt0", {gnt_o, mem_req_o, mem_adr_o}, {3'b001, 1'b1, 32'h300});
        req_i = '0; we_i = '0;

        // Backpressure: owner inputs churn while the port is held
        do_reset();
        req_i = 3'b001;
        we_i  = 3'b001;
        adr_i = {32'h0, 32'h0, 32'hA0};
        dat_i = {32'h0, 32'h0, 32'h11};
        @(negedge clk);
        for (int i = 0; i < BP_CYCLES; i++) begin
            adr_i = {$urandom, $urandom, $urandom};
            dat_i = {$urandom, $urandom, $urandom};
            we_i  = 3'($urandom);
            @(negedge clk);
            check("bp_stable", {mem_req_o, mem_we_o, mem_adr_o, mem_dat_o, ack_o},
                  {1'b1, 1'b1, 32'hA0, 32'h11, 3'b000});
        end
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("bp_ack", {ack_o, err_o, mem_req_o}, {3'b001, 1'b0, 1'b0});
        req_i = '0;

        // Reset in the middle of an access
        do_reset();
        req_i = 3'b010;
        @(negedge clk);
        check("rst_mid_issue", 128'(gnt_o), 128'(3'b010));
        @(negedge clk);
        rst       = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        check("rst_mid_zero", dut_vec(), 128'(0));
        @(negedge clk);
        rst       = 1'b0;
        mem_ack_i = 1'b0;
        req_i     = 3'b110;
        @(negedge clk);
        check("rst_mid_ptr", {gnt_o, ack_o, mem_req_o}, {3'b010, 3'b000, 1'b1});
        req_i = '0;

`ifdef MMU_ARB_TIMEOUT_EN
        // Watchdog abort with lock held
        do_reset();
        req_i  = 3'b010;
        lock_i = 3'b010;
        @(negedge clk);
        check("to_issue", {gnt_o, mem_req_o}, {3'b010, 1'b1});
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk);
            check("to_waiting", {ack_o, mem_req_o}, {3'b000, 1'b1});
        end
        @(negedge clk);
        check("to_abort", {ack_o, err_o, dat_o, mem_req_o, gnt_o}, {3'b010, 1'b1, 32'h0, 1'b0, 3'b000});
        @(negedge clk);
        check("to_idle", {gnt_o, err_o, ack_o}, {3'b000, 1'b0, 3'b000});
        req_i = '0; lock_i = '0;
`endif

        // Randomized run against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("random", dut_vec(), model_vec());
            req_i     = 3'($urandom);
            we_i      = 3'($urandom);
            lock_i    = 3'($urandom);
            adr_i     = {$urandom, $urandom, $urandom};
            dat_i     = {$urandom, $urandom, $urandom};
            mem_dat_i = $urandom;
            mem_ack_i = ($urandom_range(0, 3) == 0);
            model_step();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
